// File: rtl/pacman_pkg.sv
// Shared maze constants, pellet encodings and tile-coordinate types for the
// playfield blocks.
package pacman_pkg;

    localparam int MAZE_COLS = 28;
    localparam int MAZE_ROWS = 31;

    localparam logic [1:0] PEL_NONE  = 2'd0;
    localparam logic [1:0] PEL_DOT   = 2'd1;
    localparam logic [1:0] PEL_POWER = 2'd2;

    typedef logic [4:0] tile_t;

    typedef enum logic {
        ST_FILL,
        ST_IDLE
    } fill_state_t;

    function automatic logic is_pellet(input logic [1:0] v);
        return (v == PEL_DOT) || (v == PEL_POWER);
    endfunction

    // Reserved code 3 is shown as an empty tile.
    function automatic logic [1:0] pel_visible(input logic [1:0] v);
        return is_pellet(v) ? v : PEL_NONE;
    endfunction

endpackage

// File: rtl/pellet_map_if.sv
// CPU-side pellet bus: tile select, clear strobe, pellet read-back and eat events.
interface pellet_map_if;
    import pacman_pkg::*;

    tile_t      pellet_x;
    tile_t      pellet_y;
    logic       pellet_clear;
    logic [1:0] pellet_data;
    logic       eat_valid;
    logic [1:0] eat_type;

    modport master (
        output pellet_x, pellet_y, pellet_clear,
        input  pellet_data, eat_valid, eat_type
    );

    modport slave (
        input  pellet_x, pellet_y, pellet_clear,
        output pellet_data, eat_valid, eat_type
    );

endinterface

// File: rtl/pellet_init_rom.sv
// Standard maze pellet layout ('.' dot, 'o' power pellet), linear index in,
// pellet type out one cycle later.
module pellet_init_rom
    import pacman_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [1:0]    pellet
);

    localparam int DEPTH = MAZE_COLS * MAZE_ROWS;

    localparam logic [0:MAZE_ROWS-1][8*MAZE_COLS-1:0] MAZE = {
        "############################",
        "#............##............#",
        "#.####.#####.##.#####.####.#",
        "#o####.#####.##.#####.####o#",
        "#.####.#####.##.#####.####.#",
        "#..........................#",
        "#.####.##.########.##.####.#",
        "#.####.##.########.##.####.#",
        "#......##....##....##......#",
        "######.##### ## #####.######",
        "     #.##### ## #####.#     ",
        "     #.##          ##.#     ",
        "     #.## ######## ##.#     ",
        "######.## #      # ##.######",
        "      .   #      #   .      ",
        "######.## #      # ##.######",
        "     #.## ######## ##.#     ",
        "     #.##          ##.#     ",
        "     #.## ######## ##.#     ",
        "######.## ######## ##.######",
        "#............##............#",
        "#.####.#####.##.#####.####.#",
        "#.####.#####.##.#####.####.#",
        "#o..##.......  .......##..o#",
        "###.##.##.########.##.##.###",
        "###.##.##.########.##.##.###",
        "#......##....##....##......#",
        "#.##########.##.##########.#",
        "#.##########.##.##########.#",
        "#..........................#",
        "############################"
    };

    logic [1:0] rom_tbl [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_tile
            localparam int ROW = gi / MAZE_COLS;
            localparam int COL = gi % MAZE_COLS;
            localparam logic [7:0] CH = MAZE[ROW][8*(MAZE_COLS-1-COL) +: 8];
            assign rom_tbl[gi] = (CH == "o") ? PEL_POWER :
                                 (CH == ".") ? PEL_DOT   : PEL_NONE;
        end
    endgenerate

    always_ff @(posedge clk) begin
        pellet <= rom_tbl[addr];
    end

endmodule

// File: rtl/pellet_map.sv
// Maze pellet store with CPU clear/read port, renderer read port and ROM refill.
// Optional PELLET_FLASH_EN blanks power pellets on the video port while frame[3] = 1.
module pellet_map
    import pacman_pkg::*;
#(
    parameter int COLS  = MAZE_COLS,
    parameter int ROWS  = MAZE_ROWS,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    pellet_map_if.slave      cpu,
    input  logic             refill,
    input  tile_t            vid_x,
    input  tile_t            vid_y,
    output logic [1:0]       vid_pellet,
    input  logic [5:0]       frame,
    output logic [CNT_W-1:0] remaining,
    output logic             busy
);

    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH + 1);

    function automatic logic [AW-1:0] tile_addr(input tile_t x, input tile_t y);
        return AW'(y) * AW'(COLS) + AW'(x);
    endfunction

    fill_state_t      state_reg;
    logic [AW-1:0]    idx_reg;
    logic [AW-1:0]    wr_idx_reg;
    logic             wr_pend_reg;
    logic [1:0]       rom_q;
    logic [1:0]       ram [DEPTH];
    logic [1:0]       cpu_rd_reg;
    logic [1:0]       vid_rd_reg;
    logic             cpu_ok_reg;
    logic             vid_ok_reg;
    logic             clr_pend_reg;
    logic [AW-1:0]    clr_addr_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic             eat_valid_reg;
    logic [1:0]       eat_type_reg;
    logic [1:0]       vid_show;

    logic [AW-1:0] cpu_addr;
    logic [AW-1:0] vid_addr;
    logic          cpu_in_range;
    logic          vid_in_range;
    logic          fill_we;
    logic          fill_done;
    logic          clr_issue;
    logic          clr_we;

    assign cpu_addr     = tile_addr(cpu.pellet_x, cpu.pellet_y);
    assign vid_addr     = tile_addr(vid_x, vid_y);
    assign cpu_in_range = (int'(cpu.pellet_x) < COLS) && (int'(cpu.pellet_y) < ROWS);
    assign vid_in_range = (int'(vid_x) < COLS) && (int'(vid_y) < ROWS);

    assign fill_we   = (state_reg == ST_FILL) && wr_pend_reg;
    assign fill_done = fill_we && (wr_idx_reg == AW'(DEPTH - 1));
    // Refill beats both a new clear and one already waiting on its RAM read.
    assign clr_issue = (state_reg == ST_IDLE) && cpu.pellet_clear && cpu_in_range && !refill;
    assign clr_we    = (state_reg == ST_IDLE) && clr_pend_reg && is_pellet(cpu_rd_reg) && !refill;

    pellet_init_rom #(.AW(AW)) u_rom (
        .clk    (clk),
        .addr   (idx_reg),
        .pellet (rom_q)
    );

    // The CPU read doubles as the clear lookup; forward the in-flight clear so
    // a repeated clear of the same tile sees it empty.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            ram[wr_idx_reg] <= rom_q;
        end else if (clr_we) begin
            ram[clr_addr_reg] <= PEL_NONE;
        end
        cpu_rd_reg <= (clr_we && (clr_addr_reg == cpu_addr)) ? PEL_NONE : ram[cpu_addr];
        vid_rd_reg <= ram[vid_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_FILL;
            idx_reg       <= '0;
            wr_idx_reg    <= '0;
            wr_pend_reg   <= 1'b0;
            cpu_ok_reg    <= 1'b0;
            vid_ok_reg    <= 1'b0;
            clr_pend_reg  <= 1'b0;
            clr_addr_reg  <= '0;
            remaining_reg <= '0;
            eat_valid_reg <= 1'b0;
            eat_type_reg  <= PEL_NONE;
        end else begin
            cpu_ok_reg    <= cpu_in_range;
            vid_ok_reg    <= vid_in_range;
            clr_pend_reg  <= clr_issue;
            clr_addr_reg  <= cpu_addr;
            eat_valid_reg <= clr_we;
            eat_type_reg  <= clr_we ? cpu_rd_reg : PEL_NONE;
            if (refill) begin
                state_reg     <= ST_FILL;
                idx_reg       <= '0;
                wr_pend_reg   <= 1'b0;
                remaining_reg <= '0;
            end else begin
                case (state_reg)
                    ST_FILL: begin
                        wr_pend_reg <= (idx_reg < AW'(DEPTH));
                        wr_idx_reg  <= idx_reg;
                        if (idx_reg < AW'(DEPTH)) begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                        if (fill_we && is_pellet(rom_q)) begin
                            remaining_reg <= remaining_reg + 1'b1;
                        end
                        if (fill_done) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    ST_IDLE: begin
                        if (clr_we && (remaining_reg != '0)) begin
                            remaining_reg <= remaining_reg - 1'b1;
                        end
                    end
                    default: state_reg <= ST_FILL;
                endcase
            end
        end
    end

`ifdef PELLET_FLASH_EN
    logic flash_reg;
    logic unused_frame;
    assign unused_frame = ^{frame[5:4], frame[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            flash_reg <= 1'b0;
        end else begin
            flash_reg <= frame[3];
        end
    end

    assign vid_show = (flash_reg && (vid_rd_reg == PEL_POWER)) ? PEL_NONE : pel_visible(vid_rd_reg);
`else
    logic unused_frame;
    assign unused_frame = ^frame;
    assign vid_show     = pel_visible(vid_rd_reg);
`endif

    assign busy            = (state_reg == ST_FILL);
    assign cpu.pellet_data = (!busy && cpu_ok_reg) ? pel_visible(cpu_rd_reg) : PEL_NONE;
    assign vid_pellet      = (!busy && vid_ok_reg) ? vid_show : PEL_NONE;
    assign remaining       = remaining_reg;
    assign cpu.eat_valid   = eat_valid_reg;
    assign cpu.eat_type    = eat_type_reg;

endmodule
